// File: rtl/booth_r4_seq_mul.sv
// ============================================================================
// Module   : booth_r4_seq_mul
// Brief    : Iterative radix-4 Booth unsigned mantissa multiplier, one digit/clk
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_r4_seq_mul #(
  parameter int DWIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DWIDTH-1:0]   prod,
  output logic                  busy
);

  localparam int NDIG = DWIDTH / 2 + 1;
  localparam int AW   = 2 * DWIDTH + 2;
  localparam int BW   = 2 * NDIG + 1;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DWIDTH-1:0] r_a;
  logic [BW-1:0]     r_bx;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_acc;
  logic              w_accept;
  logic              w_last;
  logic [2:0]        w_trip;
  logic [DWIDTH:0]   w_pp;
  logic              w_neg;
  logic [AW-1:0]     w_pp_ext;
  logic [AW-1:0]     w_pp_sh;
  logic              w_unused;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_bx holds {zero pad, b, B[-1]=0}; shifting right by 2 exposes the next triplet.
  assign w_trip = r_bx[2:0];

  always_comb begin
    w_pp  = '0;
    w_neg = 1'b0;
    case (w_trip)
      3'b001, 3'b010: w_pp = {1'b0, r_a};
      3'b011:         w_pp = {r_a, 1'b0};
      3'b100: begin
        w_pp  = {~r_a, 1'b1};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp  = {1'b1, ~r_a};
        w_neg = 1'b1;
      end
      default: begin
        w_pp  = '0;
        w_neg = 1'b0;
      end
    endcase
  end

  // Extend with the sign flag (not the generator MSB) and add the +1 of the negation.
  assign w_pp_ext = {{(AW - DWIDTH - 1){w_neg}}, w_pp} + AW'(w_neg);
  assign w_pp_sh  = w_pp_ext << {r_cnt, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_bx  <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_bx  <= {{(BW - DWIDTH - 1){1'b0}}, b, 1'b0};
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc <= r_acc + w_pp_sh;
      r_bx  <= r_bx >> 2;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign prod     = r_acc[2*DWIDTH-1:0];
  assign w_unused = &{1'b0, r_acc[AW-1:2*DWIDTH]};

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mul.sv
// ============================================================================
// Module   : tb_booth_r4_seq_mul
// Brief    : Self-checking bench for booth_r4_seq_mul against plain a*b
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_r4_seq_mul;

  localparam int DW = 11;
  localparam int ND = DW / 2 + 1;
  localparam int PW = 2 * DW;
  localparam int NRAND = 1500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] prod;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] q[$];

  always #5 clk = ~clk;

  booth_r4_seq_mul #(.DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [PW-1:0] xx;
    logic [PW-1:0] yy;
    xx = PW'(x);
    yy = PW'(y);
    return xx * yy;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (prod !== '0)        begin bad++; $display("FAIL reset_prod: got %h want 0", prod); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic run_one(input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [PW-1:0] exp, input string nm);
    int lat;
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %b want 1", nm, in_ready); end
    tick();
    in_valid = 1'b0; a = ~x; b = ~y;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s_busy: busy=%b in_ready=%b want 1/0", nm, busy, in_ready);
    end
    lat = ND + 5;
    for (int k = 1; k <= ND + 4; k++) begin
      tick();
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    total++; if (lat != ND) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, ND); end
    total++; if (prod !== exp) begin bad++; $display("FAIL %s_prod: got %h want %h", nm, prod, exp); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_one_cycle: out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_directed;
    run_one(11'h7FF, 11'h7FF, 22'h3FF001, "max");
    run_one(11'h400, 11'h400, 22'h100000, "hidden");
    run_one(11'h555, 11'h2AA, 22'h0E3472, "alt");
    run_one(11'h000, 11'h7FF, 22'h000000, "a_zero");
    run_one(11'h7FF, 11'h000, 22'h000000, "b_zero");
    run_one(11'h001, 11'h7FF, 22'h0007FF, "a_one");
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] exp;
    bit seen;
    exp = ref_mul(11'h123, 11'h456);
    a = 11'h123; b = 11'h456; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 11'h7FF; b = 11'h7FF;
    seen = 1'b0;
    for (int k = 0; k < ND + 4; k++) begin
      tick();
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || prod !== exp || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold: out_valid=%b prod=%h in_ready=%b want 1/%h/0", out_valid, prod, in_ready, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_single: out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] pa [4];
    logic [DW-1:0] pb [4];
    logic [PW-1:0] exp;
    int idx, ndone, cyc, last_acc;
    bit acc, dlv;
    pa = '{11'h7FF, 11'h3A5, 11'h001, 11'h6C3};
    pb = '{11'h7FE, 11'h15A, 11'h7FF, 11'h2B9};
    q.delete();
    idx = 0; ndone = 0; cyc = 0; last_acc = -1;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (ndone < 4 && cyc < 4 * (ND + 2) + 30) begin
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        exp = (q.size() > 0) ? q.pop_front() : '1;
        total++; if (prod !== exp) begin bad++; $display("FAIL b2b_prod: got %h want %h", prod, exp); end
        ndone++;
      end
      tick();
      cyc++;
      if (acc) begin
        q.push_back(ref_mul(pa[idx], pb[idx]));
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc != ND + 2) begin
            bad++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, ND + 2);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx < 4) begin a = pa[idx]; b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    total++; if (ndone != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", ndone); end
  endtask

  task automatic test_reset_midop;
    bit leak;
    a = 11'h7FF; b = 11'h7FF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || prod !== '0) begin
      bad++; $display("FAIL midrst_async: in_ready=%b out_valid=%b busy=%b prod=%h want 1/0/0/0",
                      in_ready, out_valid, busy, prod);
    end
    tick(); tick();
    rst_n = 1'b1;
    leak = 1'b0;
    for (int k = 0; k < ND + 2; k++) begin
      tick();
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak) begin bad++; $display("FAIL midrst_leak: got 1 want 0"); end
    run_one(11'h003, 11'h005, 22'h00000F, "post_rst");
  endtask

  task automatic test_random;
    int sent, got, cyc;
    bit acc, dlv, prev_stall;
    logic [PW-1:0] held, exp;
    q.delete();
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    while (got < NRAND && cyc < NRAND * 40) begin
      in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      a         = DW'($urandom);
      b         = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (prev_stall) begin
        total++; if (out_valid !== 1'b1 || prod !== held) begin
          bad++; $display("FAIL rnd_stall: out_valid=%b prod=%h want 1/%h", out_valid, prod, held);
        end
      end
      if (dlv) begin
        exp = (q.size() > 0) ? q.pop_front() : '1;
        total++; if (prod !== exp) begin bad++; $display("FAIL rnd_prod: got %h want %h", prod, exp); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held = prod;
      if (acc) begin
        q.push_back(ref_mul(a, b));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (got != NRAND || q.size() != 0) begin
      bad++; $display("FAIL rnd_count: got %0d pending %0d want %0d/0", got, q.size(), NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
